// File: rtl/iob_fifo_sync_ctrl_pkg.sv
// Shared types for the synchronous FIFO controller.
package iob_fifo_sync_ctrl_pkg;

  // Accepted operation in one cycle, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpPop  = 2'b01,
    OpPush = 2'b10,
    OpBoth = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/iob_fifo_ptr.sv
// Wrapping FIFO pointer: W-bit counter, MSB acts as the wrap bit.
module iob_fifo_ptr #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;

  // Synchronous reset; advance by one on each accepted access, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (inc_i) begin
      ptr_q <= ptr_q + W'(1);
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/iob_fifo_sync_ctrl.sv
// Single-clock FIFO controller driving an external dual-port RAM
// (port A write-only, port B read-only with a registered read port).
module iob_fifo_sync_ctrl
  import iob_fifo_sync_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_full,
  input  logic              r_en,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              r_empty,
  output logic [ADDR_W:0]   level,
  output logic              w_ovf,
  output logic              r_udf,
  output logic              ext_mem_w_en,
  output logic [ADDR_W-1:0] ext_mem_w_addr,
  output logic [DATA_W-1:0] ext_mem_w_data,
  output logic              ext_mem_r_en,
  output logic [ADDR_W-1:0] ext_mem_r_addr,
  input  logic [DATA_W-1:0] ext_mem_r_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LVL_W = ADDR_W + 1;
  localparam logic [LVL_W-1:0] LvlOne  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LvlFull = LVL_W'(DEPTH);

  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, empty_q;
  logic             r_valid_q, w_ovf_q, r_udf_q;
  logic             push_ok, pop_ok;
  logic [LVL_W-1:0] w_ptr, r_ptr;
  fifo_op_e         op;

  // Accepts use registered flags only; reset blocks any RAM access.
  assign push_ok = w_en && !full_q && !rst;
  assign pop_ok  = r_en && !empty_q && !rst;
  assign op      = fifo_op(push_ok, pop_ok);

  iob_fifo_ptr #(
    .W (LVL_W)
  ) u_w_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (push_ok),
    .ptr_o (w_ptr)
  );

  iob_fifo_ptr #(
    .W (LVL_W)
  ) u_r_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pop_ok),
    .ptr_o (r_ptr)
  );

  // Wrap bits are kept for debug visibility; occupancy comes from level_q.
  logic unused_wrap;
  assign unused_wrap = w_ptr[ADDR_W] ^ r_ptr[ADDR_W];

  // RAM drive.
  assign ext_mem_w_en   = push_ok;
  assign ext_mem_w_addr = w_ptr[ADDR_W-1:0];
  assign ext_mem_w_data = w_data;
  assign ext_mem_r_en   = pop_ok;
  assign ext_mem_r_addr = r_ptr[ADDR_W-1:0];

  // Next occupancy: +1 on push only, -1 on pop only, else unchanged.
  always_comb begin
    level_d = level_q;
    unique case (op)
      OpPush:  level_d = level_q + LvlOne;
      OpPop:   level_d = level_q - LvlOne;
      default: level_d = level_q;
    endcase
  end

  // Registered flags, read-valid and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      r_valid_q <= 1'b0;
      w_ovf_q   <= 1'b0;
      r_udf_q   <= 1'b0;
    end else begin
      level_q   <= level_d;
      full_q    <= (level_d == LvlFull);
      empty_q   <= (level_d == '0);
      r_valid_q <= pop_ok;
      w_ovf_q   <= w_en && full_q;
      r_udf_q   <= r_en && empty_q;
    end
  end

  assign level   = level_q;
  assign w_full  = full_q;
  assign r_empty = empty_q;
  assign r_valid = r_valid_q;
  assign w_ovf   = w_ovf_q;
  assign r_udf   = r_udf_q;
  // The RAM output register supplies the one-cycle read latency.
  assign r_data  = ext_mem_r_data;

endmodule

// File: tb/tb_iob_fifo_sync_ctrl.sv
// Scoreboard bench for iob_fifo_sync_ctrl with a behavioural dual-port RAM.
module tb_iob_fifo_sync_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_en, r_en;
  logic [DW-1:0] w_data;
  logic          w_full, r_valid, r_empty, w_ovf, r_udf;
  logic [DW-1:0] r_data;
  logic [AW:0]   level;
  logic          ext_mem_w_en, ext_mem_r_en;
  logic [AW-1:0] ext_mem_w_addr, ext_mem_r_addr;
  logic [DW-1:0] ext_mem_w_data, ext_mem_r_data;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] model[$];   // FIFO contents as the bench expects them
  logic [DW-1:0] exp_q[$];   // scoreboard: data due on r_data
  logic [AW:0]   wp, rp;

  always #5 clk = ~clk;

  iob_fifo_sync_ctrl #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .w_en           (w_en),
    .w_data         (w_data),
    .w_full         (w_full),
    .r_en           (r_en),
    .r_data         (r_data),
    .r_valid        (r_valid),
    .r_empty        (r_empty),
    .level          (level),
    .w_ovf          (w_ovf),
    .r_udf          (r_udf),
    .ext_mem_w_en   (ext_mem_w_en),
    .ext_mem_w_addr (ext_mem_w_addr),
    .ext_mem_w_data (ext_mem_w_data),
    .ext_mem_r_en   (ext_mem_r_en),
    .ext_mem_r_addr (ext_mem_r_addr),
    .ext_mem_r_data (ext_mem_r_data)
  );

  // Dual-port RAM with registered read port.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ext_mem_w_en) mem[ext_mem_w_addr] <= ext_mem_w_data;
    if (ext_mem_r_en) ext_mem_r_data <= mem[ext_mem_r_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented read word against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (r_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_r_valid", 32'(r_valid), 32'd0);
        end else begin
          chk("r_data", 32'(r_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // One functional cycle: drive, check RAM drive, clock, check flags.
  task automatic drive(input logic we, input logic [DW-1:0] wd, input logic re);
    int  sz;
    logic ep, eo;
    w_en = we; w_data = wd; r_en = re;
    sz = model.size();
    ep = we && (sz < DEPTH);
    eo = re && (sz > 0);
    #1;
    chk("ext_mem_w_en", 32'(ext_mem_w_en), 32'(ep));
    chk("ext_mem_r_en", 32'(ext_mem_r_en), 32'(eo));
    if (ep) begin
      chk("ext_mem_w_addr", 32'(ext_mem_w_addr), 32'(wp[AW-1:0]));
      chk("ext_mem_w_data", 32'(ext_mem_w_data), 32'(wd));
    end
    if (eo) chk("ext_mem_r_addr", 32'(ext_mem_r_addr), 32'(rp[AW-1:0]));
    @(posedge clk);
    if (eo) begin
      exp_q.push_back(model.pop_front());
      rp = rp + 1'b1;
    end
    if (ep) begin
      model.push_back(wd);
      wp = wp + 1'b1;
    end
    #1;
    w_en = 1'b0; r_en = 1'b0;
    chk("level", 32'(level), 32'(model.size()));
    chk("w_full", 32'(w_full), 32'(model.size() == DEPTH));
    chk("r_empty", 32'(r_empty), 32'(model.size() == 0));
    chk("r_valid", 32'(r_valid), 32'(eo));
    chk("w_ovf", 32'(w_ovf), 32'(we && sz == DEPTH));
    chk("r_udf", 32'(r_udf), 32'(re && sz == 0));
  endtask

  // Reset cycle with optional concurrent requests, which must be ignored.
  task automatic do_reset(input logic we, input logic re);
    rst = 1'b1; w_en = we; w_data = 8'h5A; r_en = re;
    #1;
    chk("rst_w_en_forced", 32'(ext_mem_w_en), 32'd0);
    chk("rst_r_en_forced", 32'(ext_mem_r_en), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
    model.delete();
    wp = '0; rp = '0;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_r_empty", 32'(r_empty), 32'd1);
    chk("rst_w_full", 32'(w_full), 32'd0);
    chk("rst_r_valid", 32'(r_valid), 32'd0);
    chk("rst_w_ovf", 32'(w_ovf), 32'd0);
    chk("rst_r_udf", 32'(r_udf), 32'd0);
  endtask

  initial begin
    int sent;
    logic we, re;
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; w_data = '0;
    wp = '0; rp = '0;
    do_reset(1'b0, 1'b0);
    do_reset(1'b0, 1'b0);

    // 1: idle after reset
    repeat (3) drive(1'b0, 8'h00, 1'b0);

    // 2: three pushes, three back-to-back pops
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("t2_level", 32'(level), 32'd0);

    // 3: fill to 16, then an overflowing push
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h80 + i), 1'b0);
    chk("t3_full_level", 32'(level), 32'd16);
    drive(1'b1, 8'hEE, 1'b0);
    drive(1'b0, 8'h00, 1'b0);

    // 4: simultaneous push/pop at full, mid level, empty
    drive(1'b1, 8'hEF, 1'b1);
    repeat (10) drive(1'b0, 8'h00, 1'b1);
    chk("t4_level5", 32'(level), 32'd5);
    drive(1'b1, 8'hC5, 1'b1);
    repeat (5) drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'hE0, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);

    // 5: stream 40 words, interleaved, through the wrap
    sent = 0;
    for (int i = 0; i < 200 && (sent < 40 || model.size() > 0); i++) begin
      we = (sent < 40) && (i % 4 != 3);
      re = (i % 3 != 0) || (sent >= 40);
      if (we && model.size() < DEPTH) begin
        drive(1'b1, 8'(8'h40 + sent), re);
        sent++;
      end else begin
        drive(1'b0, 8'h00, re);
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("t5_all_sent", 32'(sent), 32'd40);

    // 6: reset with level=7 and a pop in flight
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h60 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    do_reset(1'b1, 1'b1);
    drive(1'b1, 8'hA5, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
